// File: rtl/modn_digit_counter.sv
// Synchronous modulo-MOD counter of DIGITS digits with up/down, enable, clamped parallel load,
// cascade carry and sticky overflow. Define MODN_COUNTER_SAT_EN to saturate instead of wrapping.
module modn_digit_counter #(
   parameter  int MOD    = 10,
   parameter  int DIGITS = 2,
   localparam int W      = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                en,
   input  logic                up,
   input  logic                load,
   input  logic [DIGITS*W-1:0] load_val,
   output logic [DIGITS*W-1:0] count,
   output logic                carry_out,
   output logic                ovf
);

   localparam logic [W-1:0] MAX_D = W'(MOD - 1);

   logic [W-1:0] r_digit   [DIGITS];
   logic         r_ovf;
   logic [W-1:0] w_digit_nxt [DIGITS];
   logic         w_ovf_nxt;
   logic [DIGITS-1:0] w_low_max;
   logic [DIGITS-1:0] w_low_zero;
   logic         w_all_max;
   logic         w_all_zero;
   logic         w_term;
   logic         w_hold_sat;

   function automatic logic [W-1:0] f_clamp(input logic [W-1:0] d);
      return (d > MAX_D) ? MAX_D : d;
   endfunction

   function automatic logic [W-1:0] f_inc(input logic [W-1:0] d);
      return (d == MAX_D) ? '0 : W'(d + 1'b1);
   endfunction

   function automatic logic [W-1:0] f_dec(input logic [W-1:0] d);
      return (d == '0) ? MAX_D : W'(d - 1'b1);
   endfunction

   // Digit i may move only when every lower digit is at its terminal value.
   always_comb begin
      logic v_max;
      logic v_zero;
      v_max      = 1'b1;
      v_zero     = 1'b1;
      w_low_max  = '0;
      w_low_zero = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_low_max[i]  = v_max;
         w_low_zero[i] = v_zero;
         v_max  = v_max  & (r_digit[i] == MAX_D);
         v_zero = v_zero & (r_digit[i] == '0);
      end
      w_all_max  = v_max;
      w_all_zero = v_zero;
   end

   assign w_term    = up ? w_all_max : w_all_zero;
   assign carry_out = en & ~load & w_term;

`ifdef MODN_COUNTER_SAT_EN
   assign w_hold_sat = w_term;
`else
   assign w_hold_sat = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         w_digit_nxt[i] = r_digit[i];
         if (load) begin
            w_digit_nxt[i] = f_clamp(load_val[i*W +: W]);
         end else if (en && !w_hold_sat) begin
            if (up && w_low_max[i]) begin
               w_digit_nxt[i] = f_inc(r_digit[i]);
            end else if (!up && w_low_zero[i]) begin
               w_digit_nxt[i] = f_dec(r_digit[i]);
            end
         end
      end
   end

   always_comb begin
      w_ovf_nxt = r_ovf;
      if (load) begin
         w_ovf_nxt = 1'b0;
      end else if (carry_out) begin
         w_ovf_nxt = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DIGITS; i++) begin
            r_digit[i] <= '0;
         end
         r_ovf <= 1'b0;
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            r_digit[i] <= w_digit_nxt[i];
         end
         r_ovf <= w_ovf_nxt;
      end
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < DIGITS; i++) begin
         count[i*W +: W] = r_digit[i];
      end
   end

   assign ovf = r_ovf;

endmodule

// File: tb/tb_modn_digit_counter.sv
// Bench for modn_digit_counter (MOD=10, DIGITS=2): directed scenarios plus random traffic
// against an integer-valued reference model. Honours MODN_COUNTER_SAT_EN when defined.
module tb_modn_digit_counter;

   localparam int MOD    = 10;
   localparam int DIGITS = 2;
   localparam int W      = 4;
   localparam int DW     = DIGITS * W;
   localparam int TOT    = MOD ** DIGITS;

   logic          CLK;
   logic          reset;
   logic          en;
   logic          up;
   logic          load;
   logic [DW-1:0] load_val;
   logic [DW-1:0] count;
   logic          carry_out;
   logic          ovf;

   int n_checks;
   int n_fail;
   int m_val;
   bit m_ovf;

   modn_digit_counter #(.MOD(MOD), .DIGITS(DIGITS)) dut (
      .CLK      (CLK),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .carry_out(carry_out),
      .ovf      (ovf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] to_digits(input int v);
      logic [DW-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*W +: W] = W'(t % MOD);
         t = t / MOD;
      end
      return r;
   endfunction

   function automatic int load_to_val(input logic [DW-1:0] lv);
      int s;
      int p;
      int d;
      s = 0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(lv[i*W +: W]);
         if (d >= MOD) d = MOD - 1;
         s += d * p;
         p *= MOD;
      end
      return s;
   endfunction

   function automatic bit exp_carry(input bit e, input bit u, input bit l);
      return e && !l && (u ? (m_val == TOT - 1) : (m_val == 0));
   endfunction

   task automatic model_edge(input bit e, input bit u, input bit l, input logic [DW-1:0] lv);
      bit c;
      bit sat;
      c   = exp_carry(e, u, l);
      sat = 1'b0;
`ifdef MODN_COUNTER_SAT_EN
      sat = c;
`endif
      if (l) begin
         m_val = load_to_val(lv);
         m_ovf = 1'b0;
      end else if (e) begin
         if (c) m_ovf = 1'b1;
         if (!sat) m_val = u ? (m_val + 1) % TOT : (m_val + TOT - 1) % TOT;
      end
   endtask

   // Starts and ends on a falling edge: drive, check carry, clock, check state.
   task automatic cyc(input bit e, input bit u, input bit l, input logic [DW-1:0] lv);
      en = e; up = u; load = l; load_val = lv;
      #1;
      check("carry_out", {31'd0, carry_out}, {31'd0, exp_carry(e, u, l)});
      @(posedge CLK);
      model_edge(e, u, l, lv);
      @(negedge CLK);
      check("count", {24'd0, count}, {24'd0, to_digits(m_val)});
      check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
   endtask

   // Asynchronous reset taken mid-cycle; released on the following falling edge.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      m_val = 0;
      m_ovf = 1'b0;
      check("rst_count", {24'd0, count}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      @(negedge CLK);
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_val    = 0;
      m_ovf    = 1'b0;
      reset    = 1'b1;
      en       = 1'b0;
      up       = 1'b1;
      load     = 1'b0;
      load_val = '0;
      @(negedge CLK);
      check("reset_count", {24'd0, count}, 32'd0);
      check("reset_ovf", {31'd0, ovf}, 32'd0);
      reset = 1'b0;

      // Up count through the full range and wrap.
      for (int k = 0; k < 99; k++) cyc(1, 1, 0, '0);
      check("up99", {24'd0, count}, 32'h99);
      en = 1'b1; up = 1'b1; #1;
      check("up99_carry", {31'd0, carry_out}, 32'd1);
      cyc(1, 1, 0, '0);
`ifdef MODN_COUNTER_SAT_EN
      check("up100_sat", {24'd0, count}, 32'h99);
`else
      check("up100", {24'd0, count}, 32'h00);
`endif
      check("up100_ovf", {31'd0, ovf}, 32'd1);

      // Mid-count asynchronous reset at 47.
      cyc(0, 0, 1, 8'h46);
      cyc(1, 1, 0, '0);
      check("at47", {24'd0, count}, 32'h47);
      do_reset();
      cyc(1, 1, 0, '0);
      check("after_rst", {24'd0, count}, 32'h01);

      // Down wrap from 00.
      cyc(0, 0, 1, 8'h00);
      cyc(1, 0, 0, '0);
`ifdef MODN_COUNTER_SAT_EN
      check("down_sat", {24'd0, count}, 32'h00);
`else
      check("down_wrap", {24'd0, count}, 32'h99);
      cyc(1, 0, 0, '0);
      check("down98", {24'd0, count}, 32'h98);
`endif
      check("down_ovf", {31'd0, ovf}, 32'd1);

      // Load clamp with en asserted: load wins and clears ovf.
      cyc(1, 1, 1, {4'd12, 4'd3});
      check("clamp", {24'd0, count}, 32'h93);
      check("clamp_ovf", {31'd0, ovf}, 32'd0);

      // Hold and direction change.
      cyc(0, 1, 1, 8'h50);
      for (int k = 0; k < 5; k++) cyc(0, 1, 0, '0);
      check("hold50", {24'd0, count}, 32'h50);
      cyc(1, 0, 0, '0);
      check("dn49", {24'd0, count}, 32'h49);
      cyc(1, 1, 0, '0);
      check("up50", {24'd0, count}, 32'h50);

`ifdef MODN_COUNTER_SAT_EN
      cyc(0, 1, 1, 8'h98);
      for (int k = 0; k < 3; k++) cyc(1, 1, 0, '0);
      check("sat99", {24'd0, count}, 32'h99);
      check("sat_ovf", {31'd0, ovf}, 32'd1);
`endif

      // Random traffic, biased towards counting, with occasional loads and resets.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 39) == 0, DW'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/modn_digit_counter.md
# modn_digit_counter

Parametrised synchronous modulo-N multi-digit counter. It is the successor to the fixed mod-10 ripple counter. Every digit is clocked from the common CLK, and the block adds up/down counting, count enable, parallel load, cascade carry and an overflow flag. It is used wherever the design needs decimal or other radix counters (timers, display counters), either standalone or cascaded via `carry_out`.

## Interface
- `MOD`, 10: radix of each digit; legal range 2..256.
- `DIGITS`, 2: number of digits; legal range 1..8.
- `W`, derived as $clog2(MOD): bits per digit; not user-overridable.
- `CLK` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high; clock CLK.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `load` input 1: parallel load strobe.
- `load_val` input DIGITS*W: load value; digit i occupies bits [i*W +: W].
- `count` output DIGITS*W: current value, with the same digit packing as `load_val`.
- `carry_out` output 1: combinational cascade strobe; the next edge wraps (or saturates) the whole counter.
- `ovf` output 1: sticky overflow/underflow flag.

## Operation
- Priority per edge: reset > load > en > hold.
- Reset: every digit is set to 0 and `ovf` is cleared.
- Load (`load`=1):
  - Each digit is set to `load_val` digit i, clamped to MOD-1 if it is ≥ MOD.
  - `ovf` is cleared.
  - `en` and `up` are ignored.
- Count up (`en`=1, `up`=1):
  - Digit 0 increments.
  - A digit at MOD-1 wraps to 0 and carries into digit i+1.
  - Digit i changes only if all lower digits are at MOD-1.
- Count down (`en`=1, `up`=0):
  - Digit 0 decrements.
  - A digit at 0 wraps to MOD-1 and borrows from digit i+1.
  - Digit i changes only if all lower digits are 0.
- Hold (`en`=0, `load`=0): `count` and `ovf` are unchanged.
- `carry_out` = `en` & ~`load` & (`up` ? all digits == MOD-1 : all digits == 0). It is purely combinational from the state and inputs.
- `ovf` is set on any edge where `carry_out`=1, and stays set until reset or load.
- Digits never hold a value ≥ MOD under any input sequence.
- Non-power-of-two MOD: the unused codes are unreachable.

## Timing
- Latency: one CLK edge from `en`, `load` or `up` to the updated `count`. There is no pipelining.
- `count` is registered.
- `carry_out` is combinational and valid in the same cycle as the terminal state. To cascade a higher stage, connect its `en` to this stage's `carry_out`.
- `ovf` is registered. It rises on the edge that performs the wrap, so it is visible one cycle after `carry_out`.
- Direction change: `up` is sampled on every edge. Reversing at any state is legal and uses no extra cycles.
- Reset assertion is asynchronous and acts immediately mid-count. Deassertion must be synchronous to CLK by the system. The first count occurs on the first rising edge with `reset`=0.
- `load` and `en` asserted together: load wins, no count occurs, and `carry_out`=0.

## Configuration
- `MODN_COUNTER_SAT_EN` defined: saturating mode.
  - Counting up at all-(MOD-1), or down at all-0, holds the value instead of wrapping.
  - `carry_out` is still asserted in that cycle, and `ovf` is still set.
- Not defined (default): wrap-around as described under Operation.

## Test plan
- Reset then up-count (MOD=10, DIGITS=2, `en`=1, `up`=1):
  - After 99 edges, `count`=99 and `carry_out`=1.
  - Edge 100 gives `count`=00.
  - `ovf`=1 from edge 100 onward.
- Down wrap: load 00, then `up`=0, `en`=1.
  - `carry_out`=1 in the cycle after the load.
  - The next edge gives `count`=99 and `ovf`=1.
  - The next edge gives 98.
- Load clamp and priority: `load_val` digits {12, 3} with `load`=1 and `en`=1 in the same cycle gives `count` digits {9, 3}. There is no increment, and `ovf` is cleared.
- Mid-count reset: count up to 47, assert `reset` mid-cycle.
  - `count`=00 and `ovf`=0 immediately, without waiting for CLK.
  - After release, the next edge gives 01.
- Hold and direction change:
  - At 50, `en`=0 for 5 edges: `count` stays 50.
  - Then `en`=1, `up`=0: 49.
  - Then `up`=1: 50.
- `MODN_COUNTER_SAT_EN` build: up-count from 98.
  - Edges give 99, 99, 99.
  - `carry_out`=1 while at 99, and `ovf`=1 after the first saturating edge.
